fifo_spi_master: RTL and testbench
==================================

# fifo_spi_master

Read-side consumer of the 41-bit asynchronous command FIFO in the AHB-Lite-to-SPI bridge. Runs entirely in the read clock domain. Pops one command word at a time, serialises it as a single SPI mode-0 frame, and (optionally) returns the 32-bit read data captured from MISO. Sits between the FIFO read port and the chip pins.

## Interface
- `CLK_DIV`, 2: SCLK half-period in `rd_clk` cycles; legal range 1..255.
- `DATA_WIDTH`, 41: FIFO word width; fixed at 41 (bit 40 = write flag, 39:32 = address, 31:0 = data).

Ports:
- `rd_clk` in 1: sole clock.
- `rd_rst_n` in 1: reset, asynchronous, active-low.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_en` out 1: one-cycle pop strobe.
- `fifo_rd_data` in 41: FIFO output word, valid the cycle after `fifo_rd_en`.
- `spi_sclk` out 1: SPI clock, idle low.
- `spi_cs_n` out 1: chip select, active-low.
- `spi_mosi` out 1: serial data out, MSB first.
- `spi_miso` in 1: serial data in.
- `busy` out 1: high from pop until end of the inter-frame gap.
- `rsp_valid` out 1: one-cycle pulse at the end of a read frame.
- `rsp_data` out 32: captured read data, held until the next pulse.

## Operation
- States: IDLE, POP, LOAD, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP.
- IDLE: if `!fifo_empty`, assert `fifo_rd_en` for one cycle and go to POP; `busy` goes high.
- POP: wait one cycle for the word.
- LOAD: capture `fifo_rd_data` into a 41-bit shift register and latch the write flag.
- SETUP: `spi_cs_n`=0, `spi_mosi`=bit 40, `spi_sclk`=0; hold for CLK_DIV cycles.
- SHIFT_HI (CLK_DIV cycles): `spi_sclk`=1. On entry, sample `spi_miso` into the receive register.
- SHIFT_LO (CLK_DIV cycles): `spi_sclk`=0. On entry, shift the TX register left so MOSI presents the next bit.
- Bit counter runs 0..40. After bit 40's SHIFT_LO, go to HOLD.
- Frame is 41 bits: flag, 8 address bits, then 32 data bits.
- Read frame (flag=0): MOSI drives 0 during the 32 data bits. The receive register keeps only the last 32 MISO samples.
- HOLD (CLK_DIV cycles): `spi_cs_n` stays low and `spi_sclk` stays low. Then `spi_cs_n` goes to 1.
- GAP (CLK_DIV cycles): `spi_cs_n` high. Then return to IDLE; `busy` drops.
- `fifo_empty` is ignored outside IDLE. At most one word is in flight; pops never occur back-to-back.
- Reset mid-frame: all outputs return to reset values asynchronously. The in-flight word is discarded; no `rsp_valid` is issued for it.
- Reset values: `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `fifo_rd_en`=0, `busy`=0, `rsp_valid`=0, `rsp_data`=0.
- All outputs are registered.

## Timing
- T0 is the cycle with `fifo_rd_en`=1.
- Word captured at the end of T1.
- `spi_cs_n` low from T2.
- Bit i: rising SCLK edge at T2+CLK_DIV·(1+2i); falling SCLK edge at T2+CLK_DIV·(2+2i).
- `spi_cs_n` high at T2+83·CLK_DIV.
- `rsp_valid` pulses in the same cycle as `spi_cs_n` rises (read frames only).
- Earliest next `fifo_rd_en` at T2+84·CLK_DIV.
- CLK_DIV=2: CS low for 166 cycles; pop-to-pop period is 170 cycles.
- Counter widths: 8-bit divider counter, 6-bit bit counter.

## Configuration
- `FIFO_SPI_RD_RESP_EN` defined: MISO sampling, receive register, `rsp_valid` and `rsp_data` are implemented as described.
- Macro undefined: ports remain present, but `rsp_valid` and `rsp_data` are tied to 0 and `spi_miso` is ignored. Frame shape and timing are unchanged.

## Test plan
- Reset with `fifo_empty`=1 → all outputs at reset values; no `fifo_rd_en` for 100 cycles.
- Write word 0x1_A5_DEADBEEF, CLK_DIV=2 → MOSI over 41 rising edges = 1, 0xA5, 0xDEADBEEF MSB first; CS low 166 cycles; no `rsp_valid`.
- Read word 0x0_3C_00000000, slave drives 0x12345678 on MISO during the data phase → `rsp_valid` for exactly 1 cycle with `rsp_data`=0x12345678; MOSI=0 during the data phase.
- Three words preloaded, `fifo_empty` low throughout → exactly three `fifo_rd_en` pulses, 170 cycles apart; CS high for ≥2 cycles between frames.
- `rd_rst_n` asserted at bit 20 of a read frame → CS=1 and SCLK=0 immediately; no `rsp_valid`; the next queued word starts a clean frame after release.
- Macro undefined, read frame with MISO=1 → `rsp_valid` and `rsp_data` stay 0; SPI timing is identical to the macro-defined build.

Source files
------------

// File: rtl/fifo_spi_master.sv
// -----------------------------------------------------------------------------
// fifo_spi_master
//
// Read-side consumer of the 41-bit command FIFO in the AHB-Lite-to-SPI bridge.
// It pops one word at a time and sends it as one SPI mode-0 frame:
//   write flag (bit 40), 8 address bits, then 32 data bits, MSB first.
// Read frames (flag = 0) drive MOSI low during the data bits. They return the
// last 32 MISO samples as a one-cycle response.
//
// Optional feature macro: FIFO_SPI_RD_RESP_EN
//   defined   -> MISO sampling, receive register, rsp_valid / rsp_data.
//   undefined -> rsp_valid / rsp_data tied to 0 and spi_miso ignored.
//                Frame shape and timing do not change.
//
// Parameters
//   CLK_DIV     SCLK half-period in rd_clk cycles (1..255)
//   DATA_WIDTH  FIFO word width, fixed at 41
//
// Ports
//   rd_clk        sole clock
//   rd_rst_n      asynchronous active-low reset
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    one-cycle pop strobe
//   fifo_rd_data  FIFO word, valid the cycle after fifo_rd_en
//   spi_sclk      SPI clock, idle low
//   spi_cs_n      chip select, active low
//   spi_mosi      serial data out
//   spi_miso      serial data in
//   busy          high from pop until end of the inter-frame gap
//   rsp_valid     one-cycle pulse at the end of a read frame
//   rsp_data      captured read data, held until the next pulse
// -----------------------------------------------------------------------------
module fifo_spi_master #(
    parameter int CLK_DIV    = 2,
    parameter int DATA_WIDTH = 41
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  spi_sclk,
    output logic                  spi_cs_n,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic                  busy,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_data
);

    typedef enum logic [2:0] {
        IDLE, POP, LOAD, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] LAST_BIT = 6'(DATA_WIDTH - 1);
    localparam logic [5:0] HDR_BITS = 6'd9;   // flag + 8 address bits

    state_t                state, state_d;
    logic [7:0]            div_cnt, div_d;
    logic [5:0]            bit_cnt, bit_d;
    // The flag goes straight to MOSI and wr_flag, so only the remaining
    // 40 bits need to be held for shifting.
    logic [DATA_WIDTH-2:0] tx_sr, tx_d;
    logic                  wr_flag, wr_d;
    logic                  rd_en_d, sclk_d, cs_n_d, mosi_d, busy_d;
    logic                  sample_en;    // SCLK is about to rise: take MISO
    logic                  frame_done;   // CS is about to rise
    logic                  last_tick;

    assign last_tick = (div_cnt == DIV_LAST);

    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves a value unassigned, which would infer a latch.
        state_d    = state;
        bit_d      = bit_cnt;
        tx_d       = tx_sr;
        wr_d       = wr_flag;
        rd_en_d    = 1'b0;
        sclk_d     = spi_sclk;
        cs_n_d     = spi_cs_n;
        mosi_d     = spi_mosi;
        busy_d     = busy;
        sample_en  = 1'b0;
        frame_done = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = POP;
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            POP: state_d = LOAD;
            LOAD: begin
                tx_d    = fifo_rd_data[DATA_WIDTH-2:0];
                wr_d    = fifo_rd_data[DATA_WIDTH-1];
                bit_d   = '0;
                cs_n_d  = 1'b0;
                sclk_d  = 1'b0;
                mosi_d  = fifo_rd_data[DATA_WIDTH-1];
                state_d = SETUP;
            end
            SETUP, SHIFT_LO: begin
                if (last_tick) begin
                    state_d   = SHIFT_HI;
                    sclk_d    = 1'b1;
                    sample_en = 1'b1;
                end
            end
            SHIFT_HI: begin
                if (last_tick) begin
                    sclk_d = 1'b0;
                    // The low phase of the last bit is HOLD. This keeps CS low
                    // for 83 half-periods.
                    if (bit_cnt == LAST_BIT) begin
                        state_d = HOLD;
                    end else begin
                        state_d = SHIFT_LO;
                        bit_d   = bit_cnt + 6'd1;
                        tx_d    = {tx_sr[DATA_WIDTH-3:0], 1'b0};
                        // Read frames send zeros once past the header.
                        mosi_d  = tx_sr[DATA_WIDTH-2] & (wr_flag | (bit_d < HDR_BITS));
                    end
                end
            end
            HOLD: begin
                if (last_tick) begin
                    state_d    = GAP;
                    cs_n_d     = 1'b1;
                    mosi_d     = 1'b0;
                    frame_done = 1'b1;
                end
            end
            GAP: begin
                // The last gap cycle also makes the idle decision. This lets
                // the next pop land exactly 84 half-periods after CS fell.
                if (last_tick) begin
                    if (!fifo_empty) begin
                        state_d = POP;
                        rd_en_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The divider restarts on every state change.
        div_d = (state_d == state && state != IDLE) ? div_cnt + 8'd1 : 8'd0;
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            wr_flag    <= 1'b0;
            fifo_rd_en <= 1'b0;
            spi_sclk   <= 1'b0;
            spi_cs_n   <= 1'b1;
            spi_mosi   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the values from before this clock edge.
            state      <= state_d;
            div_cnt    <= div_d;
            bit_cnt    <= bit_d;
            tx_sr      <= tx_d;
            wr_flag    <= wr_d;
            fifo_rd_en <= rd_en_d;
            spi_sclk   <= sclk_d;
            spi_cs_n   <= cs_n_d;
            spi_mosi   <= mosi_d;
            busy       <= busy_d;
        end
    end

`ifdef FIFO_SPI_RD_RESP_EN
    logic [31:0] rx_sr;

    // MISO is taken on the edge that raises SCLK. After 41 samples the
    // register holds exactly the 32 data-phase bits.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rx_sr     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= frame_done & ~wr_flag;
            if (sample_en) begin
                rx_sr <= {rx_sr[30:0], spi_miso};
            end
            if (frame_done && !wr_flag) begin
                rsp_data <= rx_sr;
            end
        end
    end
`else
    assign rsp_valid = 1'b0;
    assign rsp_data  = '0;

    logic unused_resp;
    assign unused_resp = ^{spi_miso, sample_en, frame_done};
`endif

endmodule

// File: tb/tb_fifo_spi_master.sv
// -----------------------------------------------------------------------------
// tb_fifo_spi_master
//
// Directed bench for fifo_spi_master with CLK_DIV = 2.
// A queue models the FIFO. A negedge monitor records frame shape and timing
// and acts as an SPI slave that shifts out a 41-bit word on MISO. The expected
// read data depends on whether FIFO_SPI_RD_RESP_EN is defined.
// -----------------------------------------------------------------------------
module tb_fifo_spi_master;

    localparam int CLK_DIV = 2;

`ifdef FIFO_SPI_RD_RESP_EN
    localparam bit RESP_EN = 1'b1;
`else
    localparam bit RESP_EN = 1'b0;
`endif

    logic        rd_clk = 1'b0;
    logic        rd_rst_n = 1'b1;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [40:0] fifo_rd_data = '0;
    logic        spi_sclk, spi_cs_n, spi_mosi;
    logic        spi_miso = 1'b0;
    logic        busy, rsp_valid;
    logic [31:0] rsp_data;

    fifo_spi_master #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(41)) dut (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .busy         (busy),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data)
    );

    always #5 rd_clk = ~rd_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- FIFO model ----------------
    logic [40:0] fifo_q[$];

    always @(negedge rd_clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    end

    // ---------------- monitor / SPI slave ----------------
    logic [40:0] slave_word = '0;
    logic [40:0] mosi_cap = '0;
    logic [40:0] last_mosi = '0;
    logic [40:0] mosi_frames[$];
    logic [31:0] rsp_last = '0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    int cyc = 0, rd_en_cnt = 0, last_rd_en_cyc = 0;
    int rd_times[$];
    int frames_done = 0, frames_started = 0;
    int cs_low_cnt = 0, last_cs_low = 0, cs_high_run = 0, gap_min = 1000;
    int rises = 0, last_rises = 0, first_rise_cyc = 0;
    int cs_fall_cyc = 0, cs_rise_cyc = 0, miso_idx = 0;
    int rsp_cnt = 0, rsp_align_err = 0;

    always @(negedge rd_clk) begin
        cyc++;
        if (fifo_rd_en) begin
            rd_en_cnt++;
            last_rd_en_cyc = cyc;
            rd_times.push_back(cyc);
        end
        if (prev_cs && !spi_cs_n) begin
            frames_started++;
            cs_fall_cyc = cyc;
            if (frames_done > 0 && cs_high_run < gap_min) gap_min = cs_high_run;
            cs_low_cnt = 0;
            rises = 0;
            mosi_cap = '0;
            miso_idx = 0;
            spi_miso = slave_word[40];
        end
        if (!prev_cs && spi_cs_n) begin
            frames_done++;
            cs_rise_cyc = cyc;
            last_cs_low = cs_low_cnt;
            last_mosi = mosi_cap;
            last_rises = rises;
            mosi_frames.push_back(mosi_cap);
            cs_high_run = 0;
        end
        if (!spi_cs_n) cs_low_cnt++;
        else cs_high_run++;
        if (spi_sclk && !prev_sclk) begin
            if (rises == 0) first_rise_cyc = cyc;
            mosi_cap = {mosi_cap[39:0], spi_mosi};
            rises++;
        end
        if (!spi_sclk && prev_sclk) begin
            miso_idx++;
            spi_miso = (miso_idx <= 40) ? slave_word[40 - miso_idx] : 1'b0;
        end
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_last = rsp_data;
            if (!(spi_cs_n && !prev_cs)) rsp_align_err++;
        end
        prev_cs = spi_cs_n;
        prev_sclk = spi_sclk;
    end

    // Waits until the frame count reaches target; a timeout shows up as a
    // failed comparison. Afterwards the gap is let run out.
    task automatic wait_frames(input int target, input string tag);
        int budget = 0;
        while (frames_done < target && budget < 2000) begin
            @(negedge rd_clk);
            budget++;
        end
        repeat (6) @(negedge rd_clk);
        #1;
        check(tag, 64'(frames_done), 64'(target));
    endtask

    task automatic check_frame(input string tag, input logic [40:0] exp_mosi);
        check({tag, "_mosi"}, 64'(last_mosi), 64'(exp_mosi));
        check({tag, "_cs_low"}, 64'(last_cs_low), 64'(83 * CLK_DIV));
        check({tag, "_rises"}, 64'(last_rises), 64'd41);
    endtask

    int exp_rsp = 0;
    int start, budget, base_rd, base_frames;

    initial begin
        // ---- reset with empty FIFO ----
        #2 rd_rst_n = 1'b0;
        #1;
        check("rst_cs_n", 64'(spi_cs_n), 64'd1);
        check("rst_sclk", 64'(spi_sclk), 64'd0);
        check("rst_mosi", 64'(spi_mosi), 64'd0);
        check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        repeat (3) @(negedge rd_clk);
        rd_rst_n = 1'b1;
        repeat (100) @(negedge rd_clk);
        #1;
        check("idle_no_pop", 64'(rd_en_cnt), 64'd0);
        check("idle_cs_n", 64'(spi_cs_n), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);

        // ---- write frame ----
        slave_word = '0;
        fifo_q.push_back(41'h1_A5_DEADBEEF);
        wait_frames(1, "wr_done");
        check_frame("wr", 41'h1_A5_DEADBEEF);
        check("wr_cs_fall_lat", 64'(cs_fall_cyc - last_rd_en_cyc), 64'd2);
        check("wr_first_rise_lat", 64'(first_rise_cyc - last_rd_en_cyc), 64'(2 + CLK_DIV));
        check("wr_cs_rise_lat", 64'(cs_rise_cyc - last_rd_en_cyc), 64'(2 + 83 * CLK_DIV));
        check("wr_no_rsp", 64'(rsp_cnt), 64'(exp_rsp));
        check("wr_busy_after", 64'(busy), 64'd0);

        // ---- read frame, slave returns 0x12345678 ----
        slave_word = {9'h0, 32'h12345678};
        fifo_q.push_back(41'h0_3C_00000000);
        wait_frames(2, "rd_done");
        exp_rsp += int'(RESP_EN);
        check_frame("rd", 41'h0_3C_00000000);
        check("rd_rsp_cnt", 64'(rsp_cnt), 64'(exp_rsp));
        check("rd_rsp_data", 64'(rsp_data), RESP_EN ? 64'h12345678 : 64'h0);
        check("rd_rsp_align", 64'(rsp_align_err), 64'd0);

        // ---- read frame with MISO held high ----
        slave_word = '1;
        fifo_q.push_back(41'h0_3C_00000000);
        wait_frames(3, "rd1_done");
        exp_rsp += int'(RESP_EN);
        check_frame("rd1", 41'h0_3C_00000000);
        check("rd1_rsp_cnt", 64'(rsp_cnt), 64'(exp_rsp));
        check("rd1_rsp_data", 64'(rsp_data), RESP_EN ? 64'hFFFFFFFF : 64'h0);

        // ---- three words back to back ----
        slave_word = {9'h0, 32'hA5A55A5A};
        rd_times.delete();
        mosi_frames.delete();
        gap_min = 1000;
        base_rd = rd_en_cnt;
        fifo_q.push_back(41'h1_11_01234567);
        fifo_q.push_back(41'h0_C3_FFFFFFFF);
        fifo_q.push_back(41'h1_7E_89ABCDEF);
        wait_frames(6, "burst_done");
        exp_rsp += int'(RESP_EN);
        check("burst_pops", 64'(rd_en_cnt - base_rd), 64'd3);
        if (rd_times.size() == 3) begin
            check("burst_period_1", 64'(rd_times[1] - rd_times[0]), 64'(4 + 83 * CLK_DIV));
            check("burst_period_2", 64'(rd_times[2] - rd_times[1]), 64'(4 + 83 * CLK_DIV));
        end
        check("burst_gap_ge2", 64'(gap_min >= 2), 64'd1);
        if (mosi_frames.size() == 3) begin
            check("burst_mosi_0", 64'(mosi_frames[0]), 64'h1_11_01234567);
            check("burst_mosi_1", 64'(mosi_frames[1]), 64'h0_C3_00000000);
            check("burst_mosi_2", 64'(mosi_frames[2]), 64'h1_7E_89ABCDEF);
        end
        check("burst_rsp_cnt", 64'(rsp_cnt), 64'(exp_rsp));
        check("burst_rsp_data", 64'(rsp_data), RESP_EN ? 64'hA5A55A5A : 64'h0);
        check("burst_busy_after", 64'(busy), 64'd0);

        // ---- reset in the middle of a read frame ----
        slave_word = {9'h0, 32'h87654321};
        base_frames = frames_done;
        start = frames_started;
        fifo_q.push_back(41'h0_5A_CAFEF00D);
        fifo_q.push_back(41'h1_96_13579BDF);
        budget = 0;
        while (!(frames_started > start && rises >= 21) && budget < 1000) begin
            @(negedge rd_clk);
            budget++;
        end
        check("mid_reach_bit20", 64'(budget < 1000), 64'd1);
        @(posedge rd_clk);
        #2 rd_rst_n = 1'b0;
        #1;
        check("mid_rst_cs_n", 64'(spi_cs_n), 64'd1);
        check("mid_rst_sclk", 64'(spi_sclk), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_rsp_data", 64'(rsp_data), 64'd0);
        repeat (3) @(negedge rd_clk);
        rd_rst_n = 1'b1;
        wait_frames(base_frames + 2, "mid_next_done");
        check_frame("mid_next", 41'h1_96_13579BDF);
        check("mid_no_rsp", 64'(rsp_cnt), 64'(exp_rsp));
        check("mid_rsp_data", 64'(rsp_data), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
